tile_feed_ctrl: RTL and testbench

// Sequencer for the systolic-array input queues. On one start pulse it reads a data tile and a

---
 rtl/tpu_pkg.sv | 31 +++
 rtl/tile_feed_ctrl_skew_rd_gen.sv | 53 +++++
 rtl/tile_feed_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_tile_feed_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tpu_pkg
// Description : Shared definitions for the systolic-array feed path:
//               sequencer state encoding, default geometry constants and
//               the tile-length decode helper.
// Revision    : 1.0 - initial release
// ============================================================================
package tpu_pkg;

    localparam int DEF_LANES  = 4;   // FIFO lanes per operand
    localparam int DEF_DEPTH  = 8;   // entries per FIFO
    localparam int DEF_ADDR_W = 10;  // SRAM word-address width
    localparam int CFG_LEN_W  = 4;   // width of the cfg_len field

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_DRAIN = 3'd2,
        ST_FEED  = 3'd3,
        ST_FIN   = 3'd4
    } state_t;

    // A programmed length of zero selects a full-depth tile.
    function automatic logic [CFG_LEN_W-1:0] eff_len(input logic [CFG_LEN_W-1:0] cfg,
                                                     input int depth);
        return (cfg == '0) ? CFG_LEN_W'(depth) : cfg;
    endfunction

endpackage : tpu_pkg
`default_nettype wire

// File: rtl/tile_feed_ctrl_skew_rd_gen.sv
`default_nettype none
// ============================================================================
// Module      : skew_rd_gen
// Description : Feed counter plus per-lane pop window. While en is high the
//               counter t advances every cycle; lane l pops while
//               l <= t < l+len, giving the diagonal skew the array expects.
//               t clears whenever en is low.
// Ports       : clk, rst  - clock, synchronous active-high reset
//               en        - feed phase active
//               len       - entries per lane (1..DEPTH)
//               rd_en     - per-lane pop strobes
//               last      - high in the final cycle of the feed window
// Revision    : 1.0 - initial release
// ============================================================================
module skew_rd_gen
    import tpu_pkg::*;
#(
    parameter int LANES = DEF_LANES,
    parameter int LEN_W = CFG_LEN_W,
    parameter int T_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [LEN_W-1:0] len,
    output logic [LANES-1:0] rd_en,
    output logic             last
);

    logic [T_W-1:0] r_t;
    logic [T_W-1:0] w_len_x;

    assign w_len_x = T_W'(len);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_t <= '0;
        end else if (en) begin
            r_t <= r_t + T_W'(1);
        end else begin
            r_t <= '0;
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign rd_en[l] = en && (r_t >= T_W'(l)) && (r_t < (T_W'(l) + w_len_x));
    end

    // Window closes after t = len + LANES - 2.
    assign last = en && (r_t == (w_len_x + T_W'(LANES - 2)));

endmodule : skew_rd_gen
`default_nettype wire

// File: rtl/tile_feed_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tile_feed_ctrl
// Description : Systolic-array input sequencer. On an accepted start it
//               streams a data tile then a weight tile from the operand SRAM
//               into LANES data and LANES weight FIFOs (one lane at a time,
//               honouring fifo_full), then drains the FIFOs into the array
//               with a diagonal skew.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               start, abort        - command strobe / cancel
//               cfg_*               - tile base addresses and length
//               fifo_full/empty     - FIFO status, data lanes in low half
//               sram_ren/raddr      - SRAM read port (1-cycle latency)
//               fifo_wr_en          - one-hot FIFO push, aligned to SRAM data
//               fifo_rd_en          - per-lane pop (data and weight together)
//               sys_valid           - array input valid
//               busy, done, cmd_err - status
// Revision    : 1.0 - initial release
// ============================================================================
module tile_feed_ctrl
    import tpu_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int LANES  = DEF_LANES,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [ADDR_W-1:0]    cfg_data_addr,
    input  logic [ADDR_W-1:0]    cfg_weight_addr,
    input  logic [3:0]           cfg_len,
    input  logic [2*LANES-1:0]   fifo_full,
    input  logic [2*LANES-1:0]   fifo_empty,
    output logic                 sram_ren,
    output logic [ADDR_W-1:0]    sram_raddr,
    output logic [2*LANES-1:0]   fifo_wr_en,
    output logic [LANES-1:0]     fifo_rd_en,
    output logic                 sys_valid,
    output logic                 busy,
    output logic                 done,
    output logic                 cmd_err
);

    localparam int Q_W   = (2 * LANES > 2) ? $clog2(2 * LANES) : 1;
    localparam int T_RAW = $clog2(DEPTH + LANES);
    localparam int T_W   = (T_RAW > CFG_LEN_W) ? T_RAW : CFG_LEN_W;

    localparam logic [Q_W-1:0] C_Q_LAST = Q_W'(2 * LANES - 1);
    localparam logic [Q_W-1:0] C_Q_HALF = Q_W'(LANES - 1);

    // Reject geometries the control path cannot represent.
    if (DATA_W < 1 || LANES < 1 || DEPTH < 1 || DEPTH > 15 || ADDR_W < 1) begin : g_bad_params
        $error("tile_feed_ctrl: unsupported parameter set");
    end

    state_t                 r_state;
    logic [Q_W-1:0]         r_q;            // lane being loaded, 0..2*LANES-1
    logic [CFG_LEN_W-1:0]   r_k;            // entry within lane
    logic [CFG_LEN_W-1:0]   r_len;
    logic [ADDR_W-1:0]      r_off;          // (q mod LANES)*len + k, kept incrementally
    logic [ADDR_W-1:0]      r_data_base;
    logic [ADDR_W-1:0]      r_weight_base;
    logic [2*LANES-1:0]     r_wr_en;
    logic                   r_done;
    logic                   r_cmd_err;

    logic                   w_ren;
    logic [ADDR_W-1:0]      w_base;
    logic                   w_feed_en;
    logic                   w_feed_last;

    assign w_ren     = (r_state == ST_LOAD) && !fifo_full[r_q];
    assign w_base    = (r_q <= C_Q_HALF) ? r_data_base : r_weight_base;
    assign w_feed_en = (r_state == ST_FEED);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_q           <= '0;
            r_k           <= '0;
            r_len         <= '0;
            r_off         <= '0;
            r_data_base   <= '0;
            r_weight_base <= '0;
            r_wr_en       <= '0;
            r_done        <= 1'b0;
            r_cmd_err     <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_cmd_err <= 1'b0;

            // Push strobe trails the read by the SRAM latency.
            r_wr_en <= '0;
            if (w_ren) begin
                r_wr_en[r_q] <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (&fifo_empty) begin
                            r_data_base   <= cfg_data_addr;
                            r_weight_base <= cfg_weight_addr;
                            r_len         <= eff_len(cfg_len, DEPTH);
                            r_q           <= '0;
                            r_k           <= '0;
                            r_off         <= '0;
                            r_state       <= ST_LOAD;
                        end else begin
                            r_cmd_err <= 1'b1;
                        end
                    end
                end

                ST_LOAD: begin
                    if (w_ren) begin
                        if (r_k == (r_len - CFG_LEN_W'(1))) begin
                            r_k <= '0;
                            // Offset restarts when moving from data to weight lanes.
                            r_off <= (r_q == C_Q_HALF) ? '0 : (r_off + ADDR_W'(1));
                            if (r_q == C_Q_LAST) begin
                                r_state <= ST_DRAIN;
                            end else begin
                                r_q <= r_q + Q_W'(1);
                            end
                        end else begin
                            r_k   <= r_k + CFG_LEN_W'(1);
                            r_off <= r_off + ADDR_W'(1);
                        end
                    end
                end

                ST_DRAIN: begin
                    r_state <= ST_FEED;
                end

                ST_FEED: begin
                    if (w_feed_last) begin
                        r_done  <= 1'b1;
                        r_state <= ST_FIN;
                    end
                end

                ST_FIN: begin
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase

            // Cancellation wins over everything above, including an
            // in-flight push from the abort cycle.
            if (abort && (r_state != ST_IDLE)) begin
                r_state <= ST_IDLE;
                r_wr_en <= '0;
                r_done  <= 1'b0;
            end
        end
    end

    skew_rd_gen #(
        .LANES (LANES),
        .LEN_W (CFG_LEN_W),
        .T_W   (T_W)
    ) u_skew (
        .clk   (clk),
        .rst   (rst),
        .en    (w_feed_en),
        .len   (r_len),
        .rd_en (fifo_rd_en),
        .last  (w_feed_last)
    );

    assign sram_ren   = w_ren;
    assign sram_raddr = (r_state == ST_LOAD) ? (w_base + r_off) : '0;
    assign fifo_wr_en = r_wr_en;
    assign sys_valid  = |fifo_rd_en;
    assign busy       = (r_state != ST_IDLE);
    assign done       = r_done;
    assign cmd_err    = r_cmd_err;

endmodule : tile_feed_ctrl
`default_nettype wire

// File: tb/tb_tile_feed_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_tile_feed_ctrl
// Description : Self-checking bench for tile_feed_ctrl. Expected behaviour
//               is derived per cycle from a read count n over the whole tile
//               pair and from the cycle of the last read.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tile_feed_ctrl;

    localparam int LANES  = 4;
    localparam int DEPTH  = 8;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              abort;
    logic [ADDR_W-1:0] cfg_data_addr;
    logic [ADDR_W-1:0] cfg_weight_addr;
    logic [3:0]        cfg_len;
    logic [7:0]        fifo_full;
    logic [7:0]        fifo_empty;
    logic              sram_ren;
    logic [ADDR_W-1:0] sram_raddr;
    logic [7:0]        fifo_wr_en;
    logic [3:0]        fifo_rd_en;
    logic              sys_valid;
    logic              busy;
    logic              done;
    logic              cmd_err;

    int cmp_cnt = 0;
    int bad_cnt = 0;

    tile_feed_ctrl #(
        .DATA_W (DATA_W),
        .LANES  (LANES),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .abort           (abort),
        .cfg_data_addr   (cfg_data_addr),
        .cfg_weight_addr (cfg_weight_addr),
        .cfg_len         (cfg_len),
        .fifo_full       (fifo_full),
        .fifo_empty      (fifo_empty),
        .sram_ren        (sram_ren),
        .sram_raddr      (sram_raddr),
        .fifo_wr_en      (fifo_wr_en),
        .fifo_rd_en      (fifo_rd_en),
        .sys_valid       (sys_valid),
        .busy            (busy),
        .done            (done),
        .cmd_err         (cmd_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            bad_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag, input bit with_addr);
        chk({tag, "_ren"},   32'(sram_ren),   32'd0);
        chk({tag, "_wr"},    32'(fifo_wr_en), 32'd0);
        chk({tag, "_rd"},    32'(fifo_rd_en), 32'd0);
        chk({tag, "_sv"},    32'(sys_valid),  32'd0);
        chk({tag, "_busy"},  32'(busy),       32'd0);
        chk({tag, "_done"},  32'(done),       32'd0);
        chk({tag, "_err"},   32'(cmd_err),    32'd0);
        if (with_addr) chk({tag, "_addr"}, 32'(sram_raddr), 32'd0);
    endtask

    // stall_mode: 0 none, 1 random fifo_full, 2 hold fifo_full[2] for 5 cycles
    // kill_kind : 0 none, 1 abort in cycle kill_cyc, 2 rst in cycle kill_cyc
    task automatic run_cmd(input logic [ADDR_W-1:0] da, input logic [ADDR_W-1:0] wa,
                           input logic [3:0] cl, input int stall_mode,
                           input int kill_kind, input int kill_cyc,
                           input bit spurious, output int done_cyc);
        int L, total, half, n, pl, load_end, fs, flen, cyc, t, stall_left;
        bit pr, ren_e, fin, timed_out;
        logic [7:0]        wr_e;
        logic [3:0]        rd_e;
        logic [ADDR_W-1:0] a_e;

        L     = (cl == 4'd0) ? DEPTH : int'(cl);
        total = 2 * LANES * L;
        half  = LANES * L;
        flen  = L + LANES - 1;
        done_cyc = -1;

        start = 1'b1; abort = 1'b0; rst = 1'b0;
        cfg_data_addr = da; cfg_weight_addr = wa; cfg_len = cl;
        fifo_empty = 8'hFF; fifo_full = 8'h00;
        @(posedge clk); #1;   // edge 0: command accepted
        start = 1'b0;
        cyc = 1; n = 0; pr = 1'b0; pl = 0; load_end = -1;
        stall_left = 5; fin = 1'b0; timed_out = 1'b0;

        while (!fin) begin
            // Scramble everything the DUT must have latched or must ignore.
            cfg_data_addr   = ADDR_W'($urandom);
            cfg_weight_addr = ADDR_W'($urandom);
            cfg_len         = 4'($urandom);
            fifo_empty      = 8'($urandom);
            fifo_full       = 8'h00;
            if (stall_mode == 1 && $urandom_range(0, 99) < 25) begin
                fifo_full = 8'($urandom);
            end else if (stall_mode == 2 && n >= 2 * L && n < 3 * L && stall_left > 0) begin
                fifo_full[2] = 1'b1;
                stall_left--;
            end
            fs    = (load_end > 0) ? load_end + 2 : 1 << 30;
            start = spurious && (cyc == fs);
            abort = (kill_kind == 1) && (cyc == kill_cyc);
            rst   = (kill_kind == 2) && (cyc == kill_cyc);

            ren_e = (n < total) ? !fifo_full[n / L] : 1'b0;
            a_e   = (n < half) ? da : wa;
            a_e   = a_e + ADDR_W'(n % half);
            wr_e  = pr ? 8'(1 << pl) : 8'h00;
            rd_e  = 4'h0;
            t     = cyc - fs;
            for (int l = 0; l < LANES; l++) begin
                if (t >= l && t < l + L) rd_e[l] = 1'b1;
            end

            @(negedge clk);
            chk("ren", 32'(sram_ren), 32'(ren_e));
            if (ren_e) chk("addr", 32'(sram_raddr), 32'(a_e));
            chk("wr_en",   32'(fifo_wr_en), 32'(wr_e));
            chk("rd_en",   32'(fifo_rd_en), 32'(rd_e));
            chk("sys_vld", 32'(sys_valid),  32'(|rd_e));
            chk("busy",    32'(busy),       32'd1);
            chk("done",    32'(done),       32'(cyc == fs + flen));
            chk("cmd_err", 32'(cmd_err),    32'd0);

            if (cyc == fs + flen) begin
                done_cyc = cyc;
                fin = 1'b1;
            end
            pr = ren_e;
            pl = n / L;
            if (ren_e) begin
                n++;
                if (n == total) load_end = cyc;
            end
            if (kill_kind != 0 && cyc == kill_cyc) fin = 1'b1;
            if (cyc >= 600) begin
                timed_out = 1'b1;
                fin = 1'b1;
            end
            @(posedge clk); #1;
            cyc++;
        end

        start = 1'b0; abort = 1'b0; rst = 1'b0;
        fifo_full = 8'h00; fifo_empty = 8'hFF;
        @(negedge clk);
        chk("timeout", 32'(timed_out), 32'd0);
        chk_quiet("after", kill_kind == 2);
        @(posedge clk); #1;
        @(negedge clk);
        chk_quiet("after2", 1'b0);
    endtask

    initial begin
        int d;
        logic [ADDR_W-1:0] ra, rw;
        logic [3:0]        rl;
        int                rlen;

        rst = 1'b1; start = 1'b0; abort = 1'b0;
        cfg_data_addr = '0; cfg_weight_addr = '0; cfg_len = '0;
        fifo_full = 8'h00; fifo_empty = 8'hFF;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_quiet("reset", 1'b1);

        // Basic command, with a spurious start at the first feed cycle.
        run_cmd(10'h010, 10'h100, 4'd8, 0, 0, 0, 1'b1, d);
        chk("basic_done_cyc", 32'(d), 32'd77);

        // Short tile with address wrap.
        run_cmd(10'h3FE, 10'h200, 4'd3, 0, 0, 0, 1'b0, d);
        chk("short_done_cyc", 32'(d), 32'd32);

        // Back-pressure on lane 2 for five cycles.
        run_cmd(10'h010, 10'h100, 4'd8, 2, 0, 0, 1'b0, d);
        chk("bp_done_cyc", 32'(d), 32'd82);

        // Start with a non-empty weight FIFO.
        @(posedge clk); #1;
        start = 1'b1; fifo_empty = 8'hDF;
        @(posedge clk); #1;
        start = 1'b0; fifo_empty = 8'hFF;
        @(negedge clk);
        chk("err_pulse", 32'(cmd_err),  32'd1);
        chk("err_busy",  32'(busy),     32'd0);
        chk("err_ren",   32'(sram_ren), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("err_clear", 32'(cmd_err), 32'd0);
        chk("err_busy2", 32'(busy),    32'd0);

        // Abort in load cycle 20, then a fresh command.
        run_cmd(10'h010, 10'h100, 4'd8, 0, 1, 20, 1'b0, d);
        run_cmd(10'h010, 10'h100, 4'd8, 0, 0, 0, 1'b0, d);
        chk("post_abort_done_cyc", 32'(d), 32'd77);

        // Reset in the middle of feed, then a fresh command.
        run_cmd(10'h010, 10'h100, 4'd8, 0, 2, 70, 1'b0, d);
        run_cmd(10'h010, 10'h100, 4'd8, 0, 0, 0, 1'b0, d);
        chk("post_rst_done_cyc", 32'(d), 32'd77);

        // len = 0 behaves as a full-depth tile.
        run_cmd(10'h010, 10'h100, 4'd0, 0, 0, 0, 1'b0, d);
        chk("len0_done_cyc", 32'(d), 32'd77);

        // Randomized commands with random back-pressure.
        for (int i = 0; i < 8; i++) begin
            ra   = ADDR_W'($urandom);
            rw   = ADDR_W'($urandom);
            rl   = 4'($urandom_range(0, 8));
            rlen = (rl == 4'd0) ? DEPTH : int'(rl);
            run_cmd(ra, rw, rl, 1, 0, 0, 1'($urandom), d);
            chk("rand_done_min", 32'(d >= 2 * LANES * rlen + 1 + rlen + LANES), 32'd1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, bad_cnt);
        $finish;
    end

endmodule : tb_tile_feed_ctrl
`default_nettype wire
